// File: rtl/grf_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : grf_scoreboard                                               |
// | Brief   : Dual write-back register file with bypassed reads and a      |
// |           per-register busy scoreboard for decode hazard stalls.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module grf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy0,
    output logic              rd_busy1,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wb0_en,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_en,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam int               NREGS      = 2**ADDR_W;
    localparam logic [NREGS-1:0] c_one_hot0 = {{(NREGS-1){1'b0}}, 1'b1};
    localparam bit               c_zero_reg = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;

    logic              w_wb0_commit;
    logic              w_wb1_commit;
    logic              w_issue_ok;
    logic [NREGS-1:0]  w_wb_mask;
    logic [NREGS-1:0]  w_issue_mask;
    logic [NREGS-1:0]  w_busy_next;
    logic [ADDR_W:0]   w_busy_count_next;

    assign w_wb0_commit = wb0_en && !(c_zero_reg && (wb0_addr == '0));
    assign w_wb1_commit = wb1_en && !(c_zero_reg && (wb1_addr == '0));
    assign w_issue_ok   = issue_en && !(c_zero_reg && (issue_addr == '0));

    assign w_wb_mask    = (wb0_en ? (c_one_hot0 << wb0_addr) : '0)
                        | (wb1_en ? (c_one_hot0 << wb1_addr) : '0);
    assign w_issue_mask = w_issue_ok ? (c_one_hot0 << issue_addr) : '0;

    // Issue is applied after the write-back clear so a new producer wins.
    assign w_busy_next  = flush ? '0 : ((r_busy & ~w_wb_mask) | w_issue_mask);

    always_comb begin
        w_busy_count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_count_next = w_busy_count_next + (ADDR_W+1)'(w_busy_next[i]);
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wb0_commit) begin
                r_regs[wb0_addr] <= wb0_data;
            end
            if (w_wb1_commit) begin
                r_regs[wb1_addr] <= wb1_data;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_count_next;
        end
    end

    logic [1:0][ADDR_W-1:0] w_rd_addr;
    logic [1:0][DATA_W-1:0] w_rd_data;
    logic [1:0]             w_rd_busy;

    assign w_rd_addr[0] = rd_addr0;
    assign w_rd_addr[1] = rd_addr1;

    for (genvar gp = 0; gp < 2; gp++) begin : g_rd_port
        logic w_is_zero;
        assign w_is_zero     = c_zero_reg && (w_rd_addr[gp] == '0);
        assign w_rd_data[gp] = w_is_zero                                 ? '0       :
                               (wb1_en && (wb1_addr == w_rd_addr[gp])) ? wb1_data :
                               (wb0_en && (wb0_addr == w_rd_addr[gp])) ? wb0_data :
                                                                         r_regs[w_rd_addr[gp]];
        assign w_rd_busy[gp] = !w_is_zero && r_busy[w_rd_addr[gp]] && !w_wb_mask[w_rd_addr[gp]];
    end

    assign rd_data0   = w_rd_data[0];
    assign rd_data1   = w_rd_data[1];
    assign rd_busy0   = w_rd_busy[0];
    assign rd_busy1   = w_rd_busy[1];
    assign busy_count = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_grf_scoreboard                                            |
// | Brief   : Directed scenarios plus randomized traffic against a model.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_grf_scoreboard;

    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rd_addr0, rd_addr1, issue_addr, wb0_addr, wb1_addr;
    logic [31:0] rd_data0, rd_data1, wb0_data, wb1_data;
    logic        rd_busy0, rd_busy1, issue_en, wb0_en, wb1_en, flush;
    logic [5:0]  busy_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];

    grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_busy0(rd_busy0), .rd_busy1(rd_busy1),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .flush(flush), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
    endtask

    // Reference model: architectural state updated by the rules, one edge at a time.
    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_commit();
        if (wb0_en && wb0_addr != 0) m_regs[wb0_addr] = wb0_data;
        if (wb1_en && wb1_addr != 0) m_regs[wb1_addr] = wb1_data;
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end else begin
            if (wb0_en) m_busy[wb0_addr] = 1'b0;
            if (wb1_en) m_busy[wb1_addr] = 1'b0;
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_data(logic [4:0] a);
        if (a == 0) return '0;
        if (wb1_en && wb1_addr == a) return wb1_data;
        if (wb0_en && wb0_addr == a) return wb0_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(logic [4:0] a);
        if (a == 0) return 1'b0;
        if ((wb0_en && wb0_addr == a) || (wb1_en && wb1_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] exp_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return 6'(n);
    endfunction

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; idle(); rd_addr0 = 5; rd_addr1 = 0;
        #2;
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL por_count got=%0d exp=0", busy_count); end
        total++; if (rd_data0 !== 32'h0) begin bad++; $display("FAIL por_data got=%h exp=0", rd_data0); end
        #1 reset_n = 1'b1;
        tick();
        wb0_en = 1; wb0_addr = 5; wb0_data = 32'hDEADBEEF; issue_en = 1; issue_addr = 5;
        tick();
        idle();
        #1;
        total++; if (rd_data0 !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_data got=%h exp=deadbeef", rd_data0); end
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL pre_reset_count got=%0d exp=1", busy_count); end
        reset_n = 1'b0;
        #1;
        total++; if (rd_data0 !== 32'h0) begin bad++; $display("FAIL async_reset_data got=%h exp=0", rd_data0); end
        total++; if (rd_busy0 !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b exp=0", rd_busy0); end
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL async_reset_count got=%0d exp=0", busy_count); end
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_collision();
        wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11111111;
        wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22222222;
        rd_addr0 = 7;
        #2;
        total++; if (rd_data0 !== 32'h22222222) begin bad++; $display("FAIL collide_bypass got=%h exp=22222222", rd_data0); end
        tick();
        idle();
        #1;
        total++; if (rd_data0 !== 32'h22222222) begin bad++; $display("FAIL collide_array got=%h exp=22222222", rd_data0); end
    endtask

    task automatic test_zero_reg();
        issue_en = 1; issue_addr = 10;
        tick();
        idle();
        wb0_en = 1; wb0_addr = 0; wb0_data = 32'hFFFFFFFF; issue_en = 1; issue_addr = 0;
        rd_addr0 = 0; rd_addr1 = 0;
        #2;
        total++; if (rd_data0 !== 32'h0) begin bad++; $display("FAIL zero_bypass got=%h exp=0", rd_data0); end
        total++; if (rd_busy1 !== 1'b0) begin bad++; $display("FAIL zero_busy_now got=%b exp=0", rd_busy1); end
        tick();
        idle();
        #1;
        total++; if (rd_data1 !== 32'h0) begin bad++; $display("FAIL zero_array got=%h exp=0", rd_data1); end
        total++; if (rd_busy0 !== 1'b0) begin bad++; $display("FAIL zero_busy_next got=%b exp=0", rd_busy0); end
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL zero_count got=%0d exp=1", busy_count); end
        wb0_en = 1; wb0_addr = 10; wb0_data = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        issue_en = 1; issue_addr = 3; rd_addr0 = 3;
        tick();
        idle();
        for (int c = 2; c <= 3; c++) begin
            #1;
            total++; if (rd_busy0 !== 1'b1) begin bad++; $display("FAIL sb_busy_c%0d got=%b exp=1", c, rd_busy0); end
            total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL sb_count_c%0d got=%0d exp=1", c, busy_count); end
            tick();
        end
        wb0_en = 1; wb0_addr = 3; wb0_data = 32'hA5A5A5A5;
        #1;
        total++; if (rd_busy0 !== 1'b0) begin bad++; $display("FAIL sb_busy_c4 got=%b exp=0", rd_busy0); end
        total++; if (rd_data0 !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_data_c4 got=%h exp=a5a5a5a5", rd_data0); end
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL sb_count_c4 got=%0d exp=1", busy_count); end
        tick();
        idle();
        #1;
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL sb_count_c5 got=%0d exp=0", busy_count); end
        total++; if (rd_busy0 !== 1'b0) begin bad++; $display("FAIL sb_busy_c5 got=%b exp=0", rd_busy0); end
    endtask

    task automatic test_overlap();
        issue_en = 1; issue_addr = 9; rd_addr0 = 9;
        tick();
        idle();
        issue_en = 1; issue_addr = 9; wb1_en = 1; wb1_addr = 9; wb1_data = 32'h12345678;
        #1;
        total++; if (rd_busy0 !== 1'b0) begin bad++; $display("FAIL ovl_busy_now got=%b exp=0", rd_busy0); end
        total++; if (rd_data0 !== 32'h12345678) begin bad++; $display("FAIL ovl_data_now got=%h exp=12345678", rd_data0); end
        tick();
        idle();
        #1;
        total++; if (rd_busy0 !== 1'b1) begin bad++; $display("FAIL ovl_busy_next got=%b exp=1", rd_busy0); end
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL ovl_count got=%0d exp=1", busy_count); end
        wb0_en = 1; wb0_addr = 9; wb0_data = 32'h12345678;
        tick();
        idle();
    endtask

    task automatic test_flush();
        issue_en = 1; issue_addr = 1; tick();
        issue_addr = 2; tick();
        issue_addr = 4; tick();
        idle();
        #1;
        total++; if (busy_count !== 6'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", busy_count); end
        flush = 1; issue_en = 1; issue_addr = 6; wb0_en = 1; wb0_addr = 2; wb0_data = 32'h5;
        tick();
        idle();
        rd_addr0 = 1; rd_addr1 = 2;
        #1;
        total++; if (rd_busy0 !== 1'b0 || rd_busy1 !== 1'b0) begin bad++; $display("FAIL flush_busy12 got=%b%b exp=00", rd_busy0, rd_busy1); end
        total++; if (rd_data1 !== 32'h5) begin bad++; $display("FAIL flush_r2 got=%h exp=5", rd_data1); end
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", busy_count); end
        rd_addr0 = 4; rd_addr1 = 6;
        #1;
        total++; if (rd_busy0 !== 1'b0 || rd_busy1 !== 1'b0) begin bad++; $display("FAIL flush_busy46 got=%b%b exp=00", rd_busy0, rd_busy1); end
    endtask

    task automatic test_random();
        reset_n = 1'b0; idle(); model_clear();
        #2 reset_n = 1'b1;
        tick();
        for (int n = 0; n < 400; n++) begin
            issue_en   = ($urandom_range(0, 1) == 0);
            issue_addr = rnd_addr();
            wb0_en     = ($urandom_range(0, 4) < 2);
            wb0_addr   = rnd_addr();
            wb0_data   = $urandom;
            wb1_en     = ($urandom_range(0, 4) < 2);
            wb1_addr   = rnd_addr();
            wb1_data   = $urandom;
            flush      = ($urandom_range(0, 19) == 0);
            rd_addr0   = rnd_addr();
            rd_addr1   = ($urandom_range(0, 2) == 0) ? wb1_addr : rnd_addr();
            #1;
            total++; if (rd_data0 !== exp_data(rd_addr0)) begin bad++; $display("FAIL rnd_data0 n=%0d a=%0d got=%h exp=%h", n, rd_addr0, rd_data0, exp_data(rd_addr0)); end
            total++; if (rd_data1 !== exp_data(rd_addr1)) begin bad++; $display("FAIL rnd_data1 n=%0d a=%0d got=%h exp=%h", n, rd_addr1, rd_data1, exp_data(rd_addr1)); end
            total++; if (rd_busy0 !== exp_busy(rd_addr0)) begin bad++; $display("FAIL rnd_busy0 n=%0d a=%0d got=%b exp=%b", n, rd_addr0, rd_busy0, exp_busy(rd_addr0)); end
            total++; if (rd_busy1 !== exp_busy(rd_addr1)) begin bad++; $display("FAIL rnd_busy1 n=%0d a=%0d got=%b exp=%b", n, rd_addr1, rd_busy1, exp_busy(rd_addr1)); end
            total++; if (busy_count !== exp_count()) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, busy_count, exp_count()); end
            model_commit();
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_overlap();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
